status_event_reporter: RTL and testbench
========================================

# status_event_reporter

Consumes the sticky per-bit fault/status vector produced by the bitwise high-latch stage and turns each newly set bit into a timestamped event record. Records go out on a valid/ready stream for software or a logging DMA. The block also keeps a first-fault capture register, an overflow flag and a level interrupt. It sits directly downstream of the latch, in the same clock domain.

## Interface
Parameters:
- WIDTH, 32, width of the status vector (≥2)
- TS_WIDTH, 32, timestamp counter width
- DEPTH, 8, event FIFO depth (power of 2, ≥2)
- IDX_W (localparam), $clog2(WIDTH), width of the bit-index field

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- status_in  in  WIDTH  latched status vector from upstream
- clear  in  1  single-cycle pulse: flush events and first-fault/overflow state
- m_valid  out  1  event record available
- m_ready  in  1  consumer accepts record
- m_index  out  IDX_W  bit index of the event
- m_timestamp  out  TS_WIDTH  timestamp of the event
- first_valid  out  1  first-fault capture holds data
- first_index  out  IDX_W  index of the first fault since reset/clear
- first_timestamp  out  TS_WIDTH  timestamp of the first fault
- overflow  out  1  sticky: an event was merged/lost
- irq  out  1  level interrupt

## Operation
- Timestamp counter ts: free-running, +1 every cycle, wraps from all-ones to 0, reset 0.
- Edge detect: register prev <= status_in (reset 0). rise = status_in & ~prev. A bit that falls (upstream reset) and rises again produces a new event.
- Pending mask (reset 0): each cycle pending <= (pending & ~grant) | rise.
- Grant: if pending ≠ 0 and the FIFO can accept, the lowest-index set bit is granted. The record {index, ts at that cycle} is written and the bit is cleared from pending. At most one write per cycle.
- FIFO can accept when count < DEPTH, or when count == DEPTH and a pop (m_valid & m_ready) occurs in the same cycle.
- FIFO full: pending bits wait; nothing is dropped while they wait.
- Overflow: a rise on a bit already set in pending (and not granted that cycle) merges into the existing pending entry and sets overflow.
- First fault: when first_valid = 0 and rise ≠ 0:
  - capture first_index = lowest set index of rise and first_timestamp = current ts;
  - set first_valid.
  - Later rises do not alter the capture.
- Stream: first-word-fall-through. m_valid = FIFO non-empty. m_index/m_timestamp = head record, stable while m_valid & ~m_ready. Pop on m_valid & m_ready.
- irq = m_valid | overflow (registered-path signals only, no combinational dependence on m_ready).
- clear:
  - empties the FIFO and zeroes pending, overflow, first_valid, first_index and first_timestamp;
  - does not touch prev or ts, so bits already high do not re-trigger;
  - if rise ≠ 0 in the same cycle, those rises are applied after the clear: they enter pending, perform the first-fault capture and may set overflow only against the now-empty pending;
  - a grant in the clear cycle is suppressed.
- Reset values: all outputs 0. FIFO empty, pending 0, prev 0, ts 0. Reset mid-stream discards all queued records.

## Timing
- status_in bit rises, sampled at edge N:
  - pending set and first-fault capture at edge N;
  - FIFO write at edge N+1 (if it can accept), with m_timestamp = ts value during cycle N+1 (≥ first_timestamp + 1);
  - m_valid high after edge N+1.
- Rise-to-m_valid latency: 2 cycles with an empty FIFO.
- k bits rising together drain one per cycle, lowest index first, with consecutive timestamps.
- Throughput: 1 record/cycle sustained with m_ready held high.
- Pop and push in the same cycle when full: both occur and count is unchanged.

## Test plan
- Reset, then status_in = 0x0000_0005 at ts = 10 -> first_index = 0, first_timestamp = 10; records (0, 11) then (2, 12); irq high until both are popped.
- m_ready = 0, 12 distinct bits rise one per cycle with DEPTH = 8 -> 8 records queued, 4 bits held pending, overflow stays 0. Then m_ready = 1 -> all 12 records delivered in rise order, no loss.
- FIFO full, bit 3 pending; status_in bit 3 falls and rises again -> overflow = 1, irq = 1, exactly one record for bit 3.
- clear in the same cycle as a rise on bit 7 while the FIFO holds records -> FIFO empty, first_index = 7, pending = bit 7 only, overflow = 0.
- Hold m_valid with m_ready = 0 for 5 cycles -> m_index/m_timestamp stable. Pop while full with a pending bit -> push and pop occur together, count stays 8.
- resetn low mid-stream with 3 records queued -> all outputs 0 next cycle; bits still high in status_in re-report as new events after reset because prev is 0.

Source files
------------

// File: rtl/status_event_reporter.sv
// status_event_reporter: turns each newly set bit of a sticky status vector into a
// timestamped {index, ts} record on a FWFT valid/ready stream, with first-fault capture.
module status_event_reporter #(
  parameter  int WIDTH    = 32,
  parameter  int TS_WIDTH = 32,
  parameter  int DEPTH    = 8,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    status_in,
  input  logic                clear,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [IDX_W-1:0]    m_index,
  output logic [TS_WIDTH-1:0] m_timestamp,
  output logic                first_valid,
  output logic [IDX_W-1:0]    first_index,
  output logic [TS_WIDTH-1:0] first_timestamp,
  output logic                overflow,
  output logic                irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = IDX_W + TS_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Lowest set bit index of a vector; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [WIDTH-1:0]    pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic                first_valid_q, first_valid_d;
  logic [IDX_W-1:0]    first_index_q, first_index_d;
  logic [TS_WIDTH-1:0] first_ts_q, first_ts_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [REC_W-1:0]    mem_q [DEPTH];

  logic [WIDTH-1:0]    rise_s;
  logic                fifo_nempty_s;
  logic                pop_s;
  logic                can_accept_s;
  logic                push_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic [WIDTH-1:0]    grant_mask_s;
  logic [REC_W-1:0]    head_s;

  assign rise_s        = status_in & ~prev_q;
  assign fifo_nempty_s = (count_q != '0);
  // A clear flushes the FIFO, so neither a pop nor a grant takes effect in that cycle.
  assign pop_s         = fifo_nempty_s & m_ready & ~clear;
  assign can_accept_s  = (count_q < DEPTH_C) | pop_s;
  assign push_s        = (pending_q != '0) & can_accept_s & ~clear;
  assign grant_idx_s   = lowest_idx(pending_q);
  assign grant_mask_s  = push_s ? ({{(WIDTH-1){1'b0}}, 1'b1} << grant_idx_s) : '0;
  assign head_s        = mem_q[rd_ptr_q];

  // Next-state logic for timestamp, edge detect, pending mask, flags and FIFO pointers.
  always_comb begin
    ts_d          = ts_q + TS_WIDTH'(1);
    prev_d        = status_in;
    pending_d     = (pending_q & ~grant_mask_s) | rise_s;
    overflow_d    = overflow_q | (|(rise_s & pending_q & ~grant_mask_s));
    first_valid_d = first_valid_q;
    first_index_d = first_index_q;
    first_ts_d    = first_ts_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (clear) begin
      pending_d     = rise_s;
      overflow_d    = 1'b0;
      first_valid_d = 1'b0;
      first_index_d = '0;
      first_ts_d    = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
    end
    // Capture sees the post-clear state, so a rise in the clear cycle becomes the first fault.
    if (!first_valid_d && (rise_s != '0)) begin
      first_valid_d = 1'b1;
      first_index_d = lowest_idx(rise_s);
      first_ts_d    = ts_q;
    end else begin
      first_valid_d = first_valid_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts_q          <= '0;
      prev_q        <= '0;
      pending_q     <= '0;
      overflow_q    <= 1'b0;
      first_valid_q <= 1'b0;
      first_index_q <= '0;
      first_ts_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      ts_q          <= ts_d;
      prev_q        <= prev_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      first_valid_q <= first_valid_d;
      first_index_q <= first_index_d;
      first_ts_q    <= first_ts_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Record storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {grant_idx_s, ts_q};
    end
  end

  // Head fields are masked so the stream reads all-zero whenever nothing is queued.
  assign m_valid         = fifo_nempty_s;
  assign m_index         = fifo_nempty_s ? head_s[REC_W-1:TS_WIDTH] : '0;
  assign m_timestamp     = fifo_nempty_s ? head_s[TS_WIDTH-1:0] : '0;
  assign first_valid     = first_valid_q;
  assign first_index     = first_index_q;
  assign first_timestamp = first_ts_q;
  assign overflow        = overflow_q;
  assign irq             = fifo_nempty_s | overflow_q;

endmodule

// File: tb/tb_status_event_reporter.sv
// Directed self-checking bench for status_event_reporter (WIDTH=32, TS_WIDTH=32, DEPTH=8).
module tb_status_event_reporter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] status_in;
  logic        clear;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_index;
  logic [31:0] m_timestamp;
  logic        first_valid;
  logic [4:0]  first_index;
  logic [31:0] first_timestamp;
  logic        overflow;
  logic        irq;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ts;
  logic [31:0] t0, tr, ta, td, tc, tb;

  status_event_reporter #(.WIDTH(32), .TS_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .status_in(status_in), .clear(clear),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_timestamp(m_timestamp),
    .first_valid(first_valid), .first_index(first_index), .first_timestamp(first_timestamp),
    .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; exp_ts tracks the timestamp counter value of the new cycle.
  task automatic step();
    logic r;
    r = resetn;
    @(posedge clk);
    #1;
    if (r) exp_ts = exp_ts + 32'd1;
    else   exp_ts = 32'd0;
  endtask

  task automatic expect_rec(input string tag, input logic [4:0] idx, input logic [31:0] ts);
    check_val({tag, ".valid"}, {63'd0, m_valid}, 64'd1);
    check_val({tag, ".index"}, {59'd0, m_index}, {59'd0, idx});
    check_val({tag, ".ts"}, {32'd0, m_timestamp}, {32'd0, ts});
  endtask

  task automatic expect_all_zero(input string tag);
    check_val({tag, ".m_valid"}, {63'd0, m_valid}, 64'd0);
    check_val({tag, ".m_index"}, {59'd0, m_index}, 64'd0);
    check_val({tag, ".m_ts"}, {32'd0, m_timestamp}, 64'd0);
    check_val({tag, ".first_valid"}, {63'd0, first_valid}, 64'd0);
    check_val({tag, ".first_index"}, {59'd0, first_index}, 64'd0);
    check_val({tag, ".first_ts"}, {32'd0, first_timestamp}, 64'd0);
    check_val({tag, ".overflow"}, {63'd0, overflow}, 64'd0);
    check_val({tag, ".irq"}, {63'd0, irq}, 64'd0);
  endtask

  initial begin
    resetn = 1'b0; status_in = 32'h0; clear = 1'b0; m_ready = 1'b0; exp_ts = 32'd0;
    repeat (3) step();
    expect_all_zero("reset");
    resetn = 1'b1;
    repeat (10) step();

    // Two bits rising together at ts=10.
    status_in = 32'h0000_0005;
    step();
    check_val("t1.first_valid", {63'd0, first_valid}, 64'd1);
    check_val("t1.first_index", {59'd0, first_index}, 64'd0);
    check_val("t1.first_ts", {32'd0, first_timestamp}, 64'd10);
    check_val("t1.latency_valid", {63'd0, m_valid}, 64'd0);
    step();
    expect_rec("t1.rec0", 5'd0, 32'd11);
    check_val("t1.irq_hi", {63'd0, irq}, 64'd1);
    m_ready = 1'b1;
    step();
    expect_rec("t1.rec1", 5'd2, 32'd12);
    check_val("t1.irq_hi2", {63'd0, irq}, 64'd1);
    step();
    check_val("t1.empty", {63'd0, m_valid}, 64'd0);
    check_val("t1.irq_lo", {63'd0, irq}, 64'd0);
    m_ready = 1'b0;

    // Twelve bits rising one per cycle into an 8-deep FIFO with no consumer.
    t0 = exp_ts;
    for (int k = 0; k < 12; k++) begin
      status_in[4+k] = 1'b1;
      step();
    end
    for (int h = 0; h < 5; h++) begin
      expect_rec("t2.hold", 5'd4, t0 + 32'd1);
      step();
    end
    check_val("t2.no_overflow", {63'd0, overflow}, 64'd0);
    m_ready = 1'b1;
    tr = exp_ts;
    for (int k = 0; k < 12; k++) begin
      expect_rec("t2.drain", 5'(4 + k), (k < 8) ? (t0 + 32'd1 + 32'(k)) : (tr + 32'(k - 8)));
      step();
    end
    check_val("t2.empty", {63'd0, m_valid}, 64'd0);
    m_ready = 1'b0;

    // Fill FIFO, then bit 3 rises, falls and rises again while still pending.
    ta = exp_ts;
    status_in[23:16] = 8'hFF;
    repeat (9) step();
    status_in[3] = 1'b1;
    step();
    check_val("t3.ovf_first_rise", {63'd0, overflow}, 64'd0);
    status_in[3] = 1'b0;
    step();
    status_in[3] = 1'b1;
    step();
    check_val("t3.overflow", {63'd0, overflow}, 64'd1);
    check_val("t3.irq", {63'd0, irq}, 64'd1);
    m_ready = 1'b1;
    td = exp_ts;
    for (int k = 0; k < 8; k++) begin
      expect_rec("t3.drain", 5'(16 + k), ta + 32'd1 + 32'(k));
      step();
    end
    expect_rec("t3.bit3", 5'd3, td);
    step();
    check_val("t3.single_bit3", {63'd0, m_valid}, 64'd0);
    check_val("t3.irq_sticky", {63'd0, irq}, 64'd1);
    m_ready = 1'b0;

    // Clear coinciding with a rise on bit 7 while records are queued.
    status_in[7] = 1'b0;
    step();
    tb = exp_ts;
    status_in[26:25] = 2'b11;
    repeat (3) step();
    expect_rec("t4.queued", 5'd25, tb + 32'd1);
    tc = exp_ts;
    clear = 1'b1;
    status_in[7] = 1'b1;
    step();
    clear = 1'b0;
    check_val("t4.flushed", {63'd0, m_valid}, 64'd0);
    check_val("t4.overflow", {63'd0, overflow}, 64'd0);
    check_val("t4.first_valid", {63'd0, first_valid}, 64'd1);
    check_val("t4.first_index", {59'd0, first_index}, 64'd7);
    check_val("t4.first_ts", {32'd0, first_timestamp}, {32'd0, tc});
    check_val("t4.irq", {63'd0, irq}, 64'd0);
    step();
    expect_rec("t4.bit7", 5'd7, tc + 32'd1);
    m_ready = 1'b1;
    step();
    check_val("t4.only_bit7", {63'd0, m_valid}, 64'd0);
    m_ready = 1'b0;

    // Reset with three records queued; bits still high re-report afterwards.
    status_in = 32'h0;
    step();
    t0 = exp_ts;
    status_in = 32'h0000_0007;
    repeat (4) step();
    expect_rec("t6.queued", 5'd0, t0 + 32'd1);
    resetn = 1'b0;
    step();
    expect_all_zero("t6.reset");
    resetn = 1'b1;
    m_ready = 1'b1;
    step();
    check_val("t6.first_valid", {63'd0, first_valid}, 64'd1);
    check_val("t6.first_index", {59'd0, first_index}, 64'd0);
    check_val("t6.first_ts", {32'd0, first_timestamp}, 64'd0);
    check_val("t6.latency", {63'd0, m_valid}, 64'd0);
    step();
    expect_rec("t6.rec0", 5'd0, 32'd1);
    step();
    expect_rec("t6.rec1", 5'd1, 32'd2);
    step();
    expect_rec("t6.rec2", 5'd2, 32'd3);
    step();
    check_val("t6.empty", {63'd0, m_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
